// File: rtl/ccm_ctrl.sv
// ccm_ctrl: sequencer for one CCM convolution pass.
// Loads filter weights, then walks the padded input map in raster order while stalling
// on input-buffer availability, and counts the PEA results returned by the datapath.
module ccm_ctrl #(
    parameter int unsigned DIM_W     = 9,
    parameter int unsigned WL_W      = 4,
    parameter int unsigned DRAIN_CYC = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [WL_W-1:0]  cfg_wload,
    input  logic             data_valid,
    input  logic             sum_reg_valid,
    output logic             data_rd_en,
    output logic             weight_en,
    output logic [WL_W-1:0]  weight_addr,
    output logic             en,
    output logic             en_output,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] out_cnt
);

    localparam int unsigned DR_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWload,
        StScan,
        StDrain,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [DIM_W-1:0] width_q, height_q;
    logic [WL_W-1:0]  wload_q;
    logic [WL_W-1:0]  wl_cnt_q;
    logic [DR_W-1:0]  dr_cnt_q;
    logic [DIM_W-1:0] pos_col_q, pos_row_q;
    logic             en_q, en_output_q, done_q, cfg_err_q;
    logic [DIM_W-1:0] col_q, row_q;
    logic [CNT_W-1:0] out_cnt_q;

    logic             accept_start;
    logic             cfg_illegal;
    logic             accept;
    logic             col_last;
    logic             last_pos;
    logic             window_full;

    assign accept_start = (state_q == StIdle) && start;
    assign cfg_illegal  = (cfg_width < DIM_W'(3)) || (cfg_height < DIM_W'(3));
    assign accept       = data_rd_en && data_valid;
    assign col_last     = (pos_col_q == width_q - DIM_W'(1));
    assign last_pos     = col_last && (pos_row_q == height_q - DIM_W'(1));
    // A full 3x3 window exists once two rows and two columns lie behind the beat.
    assign window_full  = (pos_row_q >= DIM_W'(2)) && (pos_col_q >= DIM_W'(2));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the combinational handshake outputs.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b1;
        weight_en  = 1'b0;
        data_rd_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    if (cfg_illegal) begin
                        state_d = StDone;
                    end else if (cfg_wload == '0) begin
                        state_d = StScan;
                    end else begin
                        state_d = StWload;
                    end
                end
            end
            StWload: begin
                weight_en = 1'b1;
                if (wl_cnt_q == wload_q - WL_W'(1)) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                data_rd_en = 1'b1;
                if (data_valid && last_pos) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (dr_cnt_q == DR_W'(DRAIN_CYC - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Configuration latch plus weight-beat, drain and raster position counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q   <= '0;
            height_q  <= '0;
            wload_q   <= '0;
            wl_cnt_q  <= '0;
            dr_cnt_q  <= '0;
            pos_col_q <= '0;
            pos_row_q <= '0;
        end else if (accept_start) begin
            width_q   <= cfg_width;
            height_q  <= cfg_height;
            wload_q   <= cfg_wload;
            wl_cnt_q  <= '0;
            dr_cnt_q  <= '0;
            pos_col_q <= '0;
            pos_row_q <= '0;
        end else begin
            if (weight_en) begin
                wl_cnt_q <= (state_d == StWload) ? wl_cnt_q + WL_W'(1) : '0;
            end
            if (state_q == StDrain) begin
                dr_cnt_q <= dr_cnt_q + DR_W'(1);
            end
            if (accept) begin
                if (col_last) begin
                    pos_col_q <= '0;
                    pos_row_q <= pos_row_q + DIM_W'(1);
                end else begin
                    pos_col_q <= pos_col_q + DIM_W'(1);
                end
            end
        end
    end

    // Datapath strobes: one cycle behind the accepted beat; col/row hold across gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            en_output_q <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            en_q        <= accept;
            en_output_q <= accept && window_full;
            done_q      <= (state_q == StDone);
            if (accept) begin
                col_q <= pos_col_q;
                row_q <= pos_row_q;
            end
        end
    end

    // Sticky config error and saturating result counter, both cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
            out_cnt_q <= '0;
        end else if (accept_start) begin
            cfg_err_q <= cfg_illegal;
            out_cnt_q <= '0;
        end else if (busy && sum_reg_valid && (out_cnt_q != {CNT_W{1'b1}})) begin
            out_cnt_q <= out_cnt_q + CNT_W'(1);
        end
    end

    assign weight_addr = weight_en ? wl_cnt_q : '0;
    assign en          = en_q;
    assign en_output   = en_output_q;
    assign col         = col_q;
    assign row         = row_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;
    assign out_cnt     = out_cnt_q;

endmodule

// File: tb/tb_ccm_ctrl.sv
// Self-checking bench for ccm_ctrl: per-scenario tasks, beat scoreboard queue.
module tb_ccm_ctrl;

    localparam int DIM_W     = 9;
    localparam int WL_W      = 4;
    localparam int DRAIN_CYC = 3;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [DIM_W-1:0] cfg_width;
    logic [DIM_W-1:0] cfg_height;
    logic [WL_W-1:0]  cfg_wload;
    logic             data_valid;
    logic             sum_reg_valid;
    logic             data_rd_en;
    logic             weight_en;
    logic [WL_W-1:0]  weight_addr;
    logic             en;
    logic             en_output;
    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [CNT_W-1:0] out_cnt;

    int total = 0;
    int bad   = 0;

    // Expected beats, packed as {en_output, row, col}.
    logic [2*DIM_W:0] exp_q[$];

    always #5 clk = ~clk;

    ccm_ctrl #(
        .DIM_W    (DIM_W),
        .WL_W     (WL_W),
        .DRAIN_CYC(DRAIN_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_wload    (cfg_wload),
        .data_valid   (data_valid),
        .sum_reg_valid(sum_reg_valid),
        .data_rd_en   (data_rd_en),
        .weight_en    (weight_en),
        .weight_addr  (weight_addr),
        .en           (en),
        .en_output    (en_output),
        .col          (col),
        .row          (row),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .out_cnt      (out_cnt)
    );

    // One full pass. pat: 0 = data_valid always 1, 1 = 1,0,0 repeating.
    // inj: extra start pulses and cfg changes mid-pass, which must have no effect.
    task automatic run_pass(input string name, input int w, input int h, input int wl,
                            input int pat, input bit inj);
        int cyc, acc, tot, wl_eff, exp_done, limit, eo_cnt, pc, pr, exp_cnt;
        bit illegal, prev_acc, done_seen, in_scan, dv, acc_now;
        logic [2*DIM_W:0] e, obs;
        illegal   = (w < 3) || (h < 3);
        wl_eff    = illegal ? 0 : wl;
        tot       = illegal ? 0 : w * h;
        exp_cnt   = illegal ? 0 : (w - 2) * (h - 2);
        exp_done  = illegal ? 1 : -1;
        exp_q.delete();
        acc = 0; pc = 0; pr = 0; eo_cnt = 0;
        prev_acc  = 1'b0;
        done_seen = 1'b0;
        limit     = wl + 3 * w * h + 40;
        @(negedge clk);
        cfg_width     = DIM_W'(w);
        cfg_height    = DIM_W'(h);
        cfg_wload     = WL_W'(wl);
        start         = 1'b1;
        data_valid    = 1'b0;
        sum_reg_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!done_seen && cyc < limit) begin
            if (cyc == 0) begin
                total++;
                if (cfg_err !== illegal)
                    $display("FAIL %s cfg_err got=%0b exp=%0b", name, cfg_err, illegal);
                total++;
                if (busy !== 1'b1)
                    $display("FAIL %s busy_first got=%0b exp=1", name, busy);
            end
            total++;
            if (weight_en !== (cyc < wl_eff)) begin
                bad++;
                $display("FAIL %s weight_en cyc=%0d got=%0b exp=%0b", name, cyc, weight_en,
                         cyc < wl_eff);
            end
            if (cyc < wl_eff) begin
                total++;
                if (weight_addr !== WL_W'(cyc)) begin
                    bad++;
                    $display("FAIL %s weight_addr cyc=%0d got=%0d exp=%0d", name, cyc,
                             weight_addr, cyc);
                end
            end
            in_scan = !illegal && (cyc >= wl_eff) && (acc < tot);
            total++;
            if (data_rd_en !== in_scan) begin
                bad++;
                $display("FAIL %s data_rd_en cyc=%0d got=%0b exp=%0b", name, cyc, data_rd_en,
                         in_scan);
            end
            total++;
            if (en !== prev_acc) begin
                bad++;
                $display("FAIL %s en cyc=%0d got=%0b exp=%0b", name, cyc, en, prev_acc);
            end
            if (en === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s beat_extra cyc=%0d got=(%0d,%0d) exp=none", name, cyc,
                             row, col);
                end else begin
                    e   = exp_q.pop_front();
                    obs = {en_output, row, col};
                    if (obs !== e) begin
                        bad++;
                        $display("FAIL %s beat cyc=%0d got eo=%0b r=%0d c=%0d exp eo=%0b r=%0d c=%0d",
                                 name, cyc, obs[2*DIM_W], obs[2*DIM_W-1:DIM_W], obs[DIM_W-1:0],
                                 e[2*DIM_W], e[2*DIM_W-1:DIM_W], e[DIM_W-1:0]);
                    end
                end
            end
            if (en_output === 1'b1) eo_cnt++;
            if (done === 1'b1) begin
                done_seen = 1'b1;
                total++;
                if (cyc != exp_done) begin
                    bad++;
                    $display("FAIL %s done_cycle got=%0d exp=%0d", name, cyc, exp_done);
                end
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s busy_at_done got=%0b exp=0", name, busy);
                end
                total++;
                if (out_cnt !== CNT_W'(exp_cnt)) begin
                    bad++;
                    $display("FAIL %s out_cnt got=%0d exp=%0d", name, out_cnt, exp_cnt);
                end
                total++;
                if (cfg_err !== illegal) begin
                    bad++;
                    $display("FAIL %s cfg_err_end got=%0b exp=%0b", name, cfg_err, illegal);
                end
            end
            // Datapath model: one result returned the cycle after each en_output.
            sum_reg_valid = (en_output === 1'b1);
            dv            = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
            data_valid    = dv;
            start         = inj && !done_seen && (cyc == 2 || cyc == wl_eff + 4);
            if (inj && cyc == wl_eff + 2) begin
                cfg_width  = DIM_W'(7);
                cfg_height = DIM_W'(9);
                cfg_wload  = WL_W'(1);
            end
            acc_now = in_scan && dv;
            if (acc_now) begin
                exp_q.push_back({(pr >= 2 && pc >= 2), DIM_W'(pr), DIM_W'(pc)});
                acc++;
                if (acc == tot) exp_done = cyc + 1 + DRAIN_CYC + 1;
                if (pc == w - 1) begin
                    pc = 0;
                    pr++;
                end else begin
                    pc++;
                end
            end
            prev_acc = acc_now;
            @(negedge clk);
            cyc++;
        end
        start         = 1'b0;
        data_valid    = 1'b0;
        sum_reg_valid = 1'b0;
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL %s done_timeout got=none exp=cycle %0d", name, exp_done);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s beats_missing got=%0d left exp=0", name, exp_q.size());
        end
        total++;
        if (eo_cnt != exp_cnt) begin
            bad++;
            $display("FAIL %s en_output_count got=%0d exp=%0d", name, eo_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({data_rd_en, weight_en, weight_addr, en, en_output, busy, done, cfg_err} !== '0) begin
            bad++;
            $display("FAIL reset ctrl got=%b exp=0", {data_rd_en, weight_en, weight_addr, en,
                     en_output, busy, done, cfg_err});
        end
        total++;
        if ({col, row, out_cnt} !== '0) begin
            bad++;
            $display("FAIL reset counters got col=%0d row=%0d cnt=%0d exp=0", col, row, out_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_pass("basic", 4, 4, 9, 0, 1'b0);
    endtask

    // Result strobes while idle must not move the counter.
    task automatic test_idle_hold();
        @(negedge clk);
        sum_reg_valid = 1'b1;
        repeat (3) @(negedge clk);
        sum_reg_valid = 1'b0;
        total++;
        if (out_cnt !== CNT_W'(4)) begin
            bad++;
            $display("FAIL idle_hold out_cnt got=%0d exp=4", out_cnt);
        end
    endtask

    task automatic test_stall();
        run_pass("stall", 5, 3, 0, 1, 1'b0);
    endtask

    task automatic test_illegal();
        run_pass("illegal", 2, 8, 5, 0, 1'b0);
        run_pass("after_err", 3, 3, 0, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_pass("start_ignored", 4, 4, 9, 0, 1'b1);
    endtask

    // Reset lands on the edge that would accept beat (row 3, col 2) of a 5x5 pass.
    task automatic test_reset_mid_scan();
        @(negedge clk);
        cfg_width  = DIM_W'(5);
        cfg_height = DIM_W'(5);
        cfg_wload  = WL_W'(0);
        start      = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        data_valid    = 1'b1;
        sum_reg_valid = 1'b1;
        repeat (17) @(negedge clk);
        total++;
        if ({en, row, col} !== {1'b1, DIM_W'(3), DIM_W'(1)}) begin
            bad++;
            $display("FAIL mid_scan_pre got en=%0b r=%0d c=%0d exp en=1 r=3 c=1", en, row, col);
        end
        rst = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        data_valid    = 1'b0;
        sum_reg_valid = 1'b0;
        total++;
        if ({busy, en, data_rd_en} !== 3'b000) begin
            bad++;
            $display("FAIL mid_scan_ctrl got busy=%0b en=%0b rd=%0b exp=0", busy, en, data_rd_en);
        end
        total++;
        if ({col, row, out_cnt} !== '0) begin
            bad++;
            $display("FAIL mid_scan_cnt got col=%0d row=%0d cnt=%0d exp=0", col, row, out_cnt);
        end
        run_pass("after_reset", 4, 4, 2, 0, 1'b0);
    endtask

    task automatic test_max_dim();
        run_pass("max_dim", 511, 3, 0, 0, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        cfg_width     = '0;
        cfg_height    = '0;
        cfg_wload     = '0;
        data_valid    = 1'b0;
        sum_reg_valid = 1'b0;
        test_reset();
        test_basic();
        test_idle_hold();
        test_stall();
        test_illegal();
        test_start_ignored();
        test_reset_mid_scan();
        test_max_dim();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
